instruction_register: RTL and testbench
=======================================

Name: instruction_register

Overview:
- Word-wide instruction register in the CPU datapath.
- Captures the instruction word from the memory/data bus on a clock edge when the control unit asserts load, then holds it for decode.
- Also presents the held word split into opcode and address fields, plus a valid flag for the controller.
- Single clock domain; asynchronous active-high reset.

Parameters:
- word_size, 8, width of instruction word, d_in and d_out.
- op_size, 3, width of opcode field, taken from the MSBs of the held word; legal range 1..word_size-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- d_in  input  word_size  instruction word from bus.
- load  input  1  capture enable, active-high, sampled on rising clk.
- d_out  output  word_size  currently held instruction word (registered).
- opcode  output  op_size  d_out[word_size-1 : word_size-op_size], combinational from d_out.
- address  output  word_size-op_size  d_out[word_size-op_size-1 : 0], combinational from d_out.
- ir_valid  output  1  high once a word has been loaded since the last reset.

Instantiation port order for the positional form used by the CPU top and benches: d_out, d_in, rst, clk, load. The extra ports follow: opcode, address, ir_valid.

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset: while rst=1, d_out=0 and ir_valid=0 immediately, with no clock required. This forces opcode=0 and address=0.
- Reset dominates load: rst=1 with load=1 keeps d_out=0 on every edge.
- Reset deassertion: state stays at 0 until the first rising clk with load=1.
- Load: on a rising clk with rst=0 and load=1, d_out <= d_in and ir_valid <= 1.
  - Latency is 1 clock: d_out reflects d_in as sampled at that edge.
  - The new value is visible after the edge, not before.
- Hold: on a rising clk with rst=0 and load=0, d_out and ir_valid keep their values indefinitely.
- Changes on d_in between edges have no effect on d_out (no transparency).
- Back-to-back loads: each edge with load=1 captures a new word; there is no busy or handshake.
- Reset mid-operation: rst asserting at any time, including between edges or coincident with an edge, clears d_out and ir_valid at once.
- Field split is pure wiring of d_out; no arithmetic and no sign extension.
- Before the first reset, state is unspecified; the system must reset before use.
- No X propagation from load when rst=1.

Test Plan:
1. rst=1, load=1, d_in=8'hFF for 2 clocks -> d_out=8'h00, opcode=0, address=0, ir_valid=0 throughout.
2. rst=1, load=1, d_in=8'h00 -> d_out stays 8'h00.
3. rst=0, load=1, d_in=8'hFF -> after the next rising clk, d_out=8'hFF, opcode=3'b111, address=5'h1F, ir_valid=1. Nothing changes before the edge.
4. From d_out=8'hFF: load=0, d_in=8'h5A for 3 clocks -> d_out stays 8'hFF. Then load=1 -> after the next edge, d_out=8'h5A, opcode=3'b010, address=5'h1A.
5. d_out=8'hFF, load=0: assert rst=1 midway between edges -> d_out=8'h00 and ir_valid=0 before the next edge. Hold rst=1 with load=1, d_in=8'hFF -> stays 8'h00.
6. Deassert rst, then load=1 with d_in=8'hA5, 8'h3C on consecutive edges -> d_out=8'hA5 then 8'h3C, one clock each, with no bubbles.

Source files
------------

// File: rtl/instruction_register.sv
// Instruction register: captures the bus word on load and exposes opcode/address fields plus a valid flag.
// Latency 1 clk from load to d_out. There is no backpressure, so every load edge captures a new word.
module instruction_register #(
    parameter int word_size = 8,
    parameter int op_size   = 3
) (
    output logic [word_size-1:0]         d_out,
    input  logic [word_size-1:0]         d_in,
    input  logic                         rst,
    input  logic                         clk,
    input  logic                         load,
    output logic [op_size-1:0]           opcode,
    output logic [word_size-op_size-1:0] address,
    output logic                         ir_valid
);

    // Reset is tested first, so an X on load cannot reach the state while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out    <= '0;
            ir_valid <= 1'b0;
        end else if (load) begin
            d_out    <= d_in;
            ir_valid <= 1'b1;
        end
    end

    assign opcode  = d_out[word_size-1 -: op_size];
    assign address = d_out[word_size-op_size-1:0];

endmodule

// File: tb/tb_instruction_register.sv
// Directed self-checking bench for instruction_register (word_size=8, op_size=3).
module tb_instruction_register;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic [2:0] opcode;
    logic [4:0] address;
    logic       ir_valid;

    int pass_cnt;
    int total_cnt;

    instruction_register #(.word_size(8), .op_size(3)) dut (
        .d_out    (d_out),
        .d_in     (d_in),
        .rst      (rst),
        .clk      (clk),
        .load     (load),
        .opcode   (opcode),
        .address  (address),
        .ir_valid (ir_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_out,
                             input logic [2:0] e_op, input logic [4:0] e_addr,
                             input logic e_vld);
        check({tag, ".d_out"},    {24'd0, d_out},    {24'd0, e_out});
        check({tag, ".opcode"},   {29'd0, opcode},   {29'd0, e_op});
        check({tag, ".address"},  {27'd0, address},  {27'd0, e_addr});
        check({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, e_vld});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        // Reset with load active and all-ones data
        rst  = 1'b1;
        load = 1'b1;
        d_in = 8'hFF;
        #1;
        check_all("rst_async", 8'h00, 3'd0, 5'h00, 1'b0);
        step;
        check_all("rst_edge1", 8'h00, 3'd0, 5'h00, 1'b0);
        step;
        check_all("rst_edge2", 8'h00, 3'd0, 5'h00, 1'b0);

        d_in = 8'h00;
        step;
        check_all("rst_zero", 8'h00, 3'd0, 5'h00, 1'b0);

        // First load after reset release; nothing visible before the edge
        rst  = 1'b0;
        load = 1'b1;
        d_in = 8'hFF;
        #2;
        check_all("pre_edge", 8'h00, 3'd0, 5'h00, 1'b0);
        step;
        check_all("load_ff", 8'hFF, 3'b111, 5'h1F, 1'b1);

        // Hold for three edges while d_in changes
        load = 1'b0;
        d_in = 8'h5A;
        step;
        check("hold1", {24'd0, d_out}, 32'h0000_00FF);
        d_in = 8'h00;
        #2;
        d_in = 8'h5A;
        step;
        check("hold2", {24'd0, d_out}, 32'h0000_00FF);
        step;
        check_all("hold3", 8'hFF, 3'b111, 5'h1F, 1'b1);

        load = 1'b1;
        step;
        check_all("load_5a", 8'h5A, 3'b010, 5'h1A, 1'b1);

        // Back to FF, then asynchronous reset midway between edges
        d_in = 8'hFF;
        step;
        check("reload_ff", {24'd0, d_out}, 32'h0000_00FF);
        load = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_all("rst_mid", 8'h00, 3'd0, 5'h00, 1'b0);
        load = 1'b1;
        d_in = 8'hFF;
        step;
        check_all("rst_hold1", 8'h00, 3'd0, 5'h00, 1'b0);
        step;
        check_all("rst_hold2", 8'h00, 3'd0, 5'h00, 1'b0);

        // Back-to-back loads after reset release
        rst  = 1'b0;
        load = 1'b1;
        d_in = 8'hA5;
        step;
        check_all("b2b_a5", 8'hA5, 3'b101, 5'h05, 1'b1);
        d_in = 8'h3C;
        step;
        check_all("b2b_3c", 8'h3C, 3'b001, 5'h1C, 1'b1);
        load = 1'b0;
        d_in = 8'hC3;
        step;
        check_all("b2b_hold", 8'h3C, 3'b001, 5'h1C, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
